// File: rtl/ma_store_buffer.sv
// MA-stage store buffer: aligns and coalesces stores per word, drains them in
// FIFO order to the data RAM write port, and forwards byte lanes to loads.
module ma_store_buffer #(
  parameter int  AWIDTH = 14,
  parameter int  DEPTH  = 4,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_st_ma,
  input  logic              cmd_ld_ma,
  input  logic [31:0]       adr_ma,
  input  logic [31:0]       st_data_ma,
  input  logic [2:0]        ldst_code_ma,
  input  logic              rst_pipe_ma,
  input  logic              ram_busy,
  output logic              stall_sb,
  output logic [AWIDTH-1:0] ram_wadr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wen,
  output logic              fwd_hit_wb,
  output logic [3:0]        fwd_mask_wb,
  output logic [31:0]       fwd_data_wb,
  output logic              sb_empty,
  output logic [CW-1:0]     sb_count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]  r_vld;
  logic [AWIDTH-1:0] r_adr  [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic [3:0]        r_mask [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [3:0]        r_fwd_mask;
  logic [31:0]       r_fwd_data;

  logic [AWIDTH-1:0] w_wadr;
  logic              w_io;
  logic              w_legal;
  logic              w_accept;
  logic              w_ld_ok;
  logic              w_drain;
  logic              w_full;
  logic              w_merge;
  logic              w_alloc;
  logic [PW-1:0]     w_merge_idx;
  logic [PW-1:0]     w_fidx;
  logic [31:0]       w_st_data;
  logic [3:0]        w_st_mask;
  logic [31:0]       w_fwd_data;
  logic [3:0]        w_fwd_mask;
  logic              w_unused;

  assign w_wadr   = adr_ma[AWIDTH+1:2];
  assign w_io     = (adr_ma[31:30] == 2'b11);
  assign w_legal  = (ldst_code_ma <= 3'b010);
  assign w_accept = cmd_st_ma & ~rst_pipe_ma & ~w_io & w_legal;
  assign w_ld_ok  = cmd_ld_ma & ~rst_pipe_ma & ~w_io;
  assign w_drain  = (r_count != '0) & ~ram_busy;
  assign w_full   = (r_count == CW'(DEPTH));
  // A full buffer still accepts when the head leaves at the same edge.
  assign w_alloc  = w_accept & ~w_merge & (~w_full | w_drain);
  assign stall_sb = w_accept & ~w_merge & w_full & ~w_drain;
  assign w_unused = &{1'b0, adr_ma[29:AWIDTH+2]};

  always_comb begin
    w_st_data = '0;
    w_st_mask = '0;
    case (ldst_code_ma)
      3'b000: begin
        w_st_data = {24'h0, st_data_ma[7:0]} << {adr_ma[1:0], 3'b000};
        w_st_mask = 4'b0001 << adr_ma[1:0];
      end
      3'b001: begin
        w_st_data = adr_ma[1] ? {st_data_ma[15:0], 16'h0} : {16'h0, st_data_ma[15:0]};
        w_st_mask = adr_ma[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        w_st_data = st_data_ma;
        w_st_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  // The head leaving this cycle is never a merge target, so a store to its
  // word opens a fresh entry instead of being lost with the drain.
  always_comb begin
    w_merge     = 1'b0;
    w_merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_adr[i] == w_wadr) && !(w_drain && (PW'(i) == r_head))) begin
        w_merge     = 1'b1;
        w_merge_idx = PW'(i);
      end
    end
  end

  // Walk oldest to newest so later entries overwrite earlier lanes.
  always_comb begin
    w_fwd_mask = '0;
    w_fwd_data = '0;
    w_fidx     = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_fidx = r_head + PW'(k);
      if (w_ld_ok && r_vld[w_fidx] && (r_adr[w_fidx] == w_wadr)) begin
        for (int b = 0; b < 4; b++) begin
          if (r_mask[w_fidx][b]) begin
            w_fwd_mask[b]        = 1'b1;
            w_fwd_data[8*b +: 8] = r_data[w_fidx][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else begin
      if (w_drain) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_alloc) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      r_count    <= r_count + CW'(w_alloc) - CW'(w_drain);
      r_fwd_mask <= w_fwd_mask;
      r_fwd_data <= w_fwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (w_st_mask[b]) r_data[w_merge_idx][8*b +: 8] <= w_st_data[8*b +: 8];
      end
      r_mask[w_merge_idx] <= r_mask[w_merge_idx] | w_st_mask;
    end
    if (w_alloc) begin
      r_adr[r_tail]  <= w_wadr;
      r_data[r_tail] <= w_st_data;
      r_mask[r_tail] <= w_st_mask;
    end
  end

  assign ram_wadr    = r_adr[r_head];
  assign ram_wdata   = r_data[r_head];
  assign ram_wen     = w_drain ? r_mask[r_head] : 4'b0000;
  assign fwd_hit_wb  = |r_fwd_mask;
  assign fwd_mask_wb = r_fwd_mask;
  assign fwd_data_wb = r_fwd_data;
  assign sb_count    = r_count;
  assign sb_empty    = (r_count == '0);

endmodule

// File: tb/tb_ma_store_buffer.sv
// Bench for ma_store_buffer: directed vector table, hand-written corner
// sequences, and random traffic checked against a queue-based model.
module tb_ma_store_buffer;
  localparam int AWIDTH = 14;
  localparam int DEPTH  = 4;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_st_ma = 1'b0;
  logic              cmd_ld_ma = 1'b0;
  logic [31:0]       adr_ma = '0;
  logic [31:0]       st_data_ma = '0;
  logic [2:0]        ldst_code_ma = '0;
  logic              rst_pipe_ma = 1'b0;
  logic              ram_busy = 1'b0;
  logic              stall_sb;
  logic [AWIDTH-1:0] ram_wadr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_wen;
  logic              fwd_hit_wb;
  logic [3:0]        fwd_mask_wb;
  logic [31:0]       fwd_data_wb;
  logic              sb_empty;
  logic [CW-1:0]     sb_count;

  always #5 clk = ~clk;

  ma_store_buffer #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_st_ma(cmd_st_ma), .cmd_ld_ma(cmd_ld_ma),
    .adr_ma(adr_ma), .st_data_ma(st_data_ma), .ldst_code_ma(ldst_code_ma),
    .rst_pipe_ma(rst_pipe_ma), .ram_busy(ram_busy), .stall_sb(stall_sb),
    .ram_wadr(ram_wadr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
    .fwd_hit_wb(fwd_hit_wb), .fwd_mask_wb(fwd_mask_wb), .fwd_data_wb(fwd_data_wb),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [13:0] wadr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  typedef struct {
    logic        st;
    logic        ld;
    logic [31:0] adr;
    logic [31:0] d;
    logic [2:0]  code;
    logic        kill;
    logic        busy;
    logic        e_stall;
    logic [3:0]  e_wen;
    logic [13:0] e_wadr;
    logic [31:0] e_wdata;
    logic        e_hit;
    logic [3:0]  e_fmask;
    logic [31:0] e_fdata;
    logic [2:0]  e_count;
  } vec_t;

  vec_t        vt [16];
  ent_t        mq[$];
  logic [31:0] exp_q[$];
  logic        m_hit;
  logic [3:0]  m_fmask;
  logic [31:0] m_fdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] m);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic drive(input logic st, input logic ld, input logic [31:0] adr,
                       input logic [31:0] d, input logic [2:0] code,
                       input logic kill, input logic busy);
    @(negedge clk);
    cmd_st_ma = st; cmd_ld_ma = ld; adr_ma = adr; st_data_ma = d;
    ldst_code_ma = code; rst_pipe_ma = kill; ram_busy = busy;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_st_ma = 1'b0; cmd_ld_ma = 1'b0; rst_pipe_ma = 1'b0;
    ram_busy = 1'b0; adr_ma = '0; st_data_ma = '0; ldst_code_ma = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_hit = 1'b0; m_fmask = '0; m_fdata = '0;
  endtask

  task automatic m_align(input logic [2:0] code, input logic [31:0] adr, input logic [31:0] d,
                         output logic [31:0] data, output logic [3:0] mask);
    int off;
    off  = int'(adr[1:0]);
    data = '0;
    mask = '0;
    case (code)
      3'b000: begin mask = 4'(1 << off); data = (d & 32'hFF) * (32'd1 << (8 * off)); end
      3'b001: begin
        mask = adr[1] ? 4'b1100 : 4'b0011;
        data = (d & 32'hFFFF) * (adr[1] ? 32'h10000 : 32'h1);
      end
      3'b010: begin mask = 4'hF; data = d; end
      default: ;
    endcase
  endtask

  // One clock of the reference model: drain first, then merge or push.
  task automatic model_cycle(input logic st, input logic ld, input logic [31:0] adr,
                             input logic [31:0] d, input logic [2:0] code,
                             input logic kill, input logic busy, input logic rstn);
    logic        drain, acc, io, found, stall;
    logic [13:0] wa;
    logic [31:0] ad, fd, bm;
    logic [3:0]  am, fm;
    ent_t        e;
    @(negedge clk);
    cmd_st_ma = st; cmd_ld_ma = ld; adr_ma = adr; st_data_ma = d;
    ldst_code_ma = code; rst_pipe_ma = kill; ram_busy = busy; rst_n = rstn;
    #2;
    check("m_count", 32'(sb_count), mq.size());
    check("m_empty", 32'(sb_empty), 32'(mq.size() == 0));
    check("m_fwd_hit", 32'(fwd_hit_wb), 32'(m_hit));
    check("m_fwd_mask", 32'(fwd_mask_wb), 32'(m_fmask));
    check("m_fwd_data", fwd_data_wb, m_fdata);
    drain = (mq.size() > 0) && !busy;
    check("m_ram_wen", 32'(ram_wen), drain ? 32'(mq[0].mask) : 32'h0);
    if (drain) begin
      check("m_ram_wadr", 32'(ram_wadr), 32'(mq[0].wadr));
      bm = bmask(mq[0].mask);
      check("m_ram_wdata", ram_wdata & bm, mq[0].data & bm);
    end
    wa  = adr[15:2];
    io  = (adr[31:30] == 2'b11);
    acc = st && !kill && !io && (code <= 3'b010);
    m_align(code, adr, d, ad, am);
    fm = '0;
    fd = '0;
    if (ld && !kill && !io) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].wadr == wa) begin
          bm = bmask(mq[i].mask);
          fm = fm | mq[i].mask;
          fd = (fd & ~bm) | (mq[i].data & bm);
        end
      end
    end
    if (drain) void'(mq.pop_front());
    stall = 1'b0;
    if (acc) begin
      found = 1'b0;
      for (int i = 0; i < mq.size(); i++) begin
        if (!found && mq[i].wadr == wa) begin
          e      = mq[i];
          bm     = bmask(am);
          e.data = (e.data & ~bm) | (ad & bm);
          e.mask = e.mask | am;
          mq[i]  = e;
          found  = 1'b1;
        end
      end
      if (!found) begin
        if (mq.size() < DEPTH) begin
          e.wadr = wa; e.data = ad; e.mask = am;
          mq.push_back(e);
        end else begin
          stall = 1'b1;
        end
      end
    end
    check("m_stall", 32'(stall_sb), 32'(stall));
    if (!rstn) begin
      mq.delete();
      fm = '0;
      fd = '0;
    end
    m_hit = |fm; m_fmask = fm; m_fdata = fd;
  endtask

  initial begin
    logic [31:0] v;
    //          st ld adr            d          code   kl bs  stl wen     wadr     wdata          hit fmask   fdata          cnt
    vt[0]  = '{1'b0,1'b0,32'h0,       32'h0,     3'b000,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[1]  = '{1'b1,1'b0,32'h101,     32'hAB,    3'b000,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[2]  = '{1'b0,1'b1,32'h100,     32'h0,     3'b010,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd1};
    vt[3]  = '{1'b0,1'b0,32'h0,       32'h0,     3'b000,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b1,4'b0010,32'h0000AB00, 3'd1};
    vt[4]  = '{1'b0,1'b0,32'h0,       32'h0,     3'b000,1'b0,1'b0, 1'b0,4'b0010,14'h40, 32'h0000AB00, 1'b0,4'b0000,32'h0,        3'd1};
    vt[5]  = '{1'b0,1'b0,32'h0,       32'h0,     3'b000,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[6]  = '{1'b1,1'b0,32'h202,     32'hBEEF,  3'b001,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[7]  = '{1'b1,1'b0,32'h200,     32'h55,    3'b000,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd1};
    vt[8]  = '{1'b0,1'b0,32'h0,       32'h0,     3'b000,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd1};
    vt[9]  = '{1'b0,1'b0,32'h0,       32'h0,     3'b000,1'b0,1'b0, 1'b0,4'b1101,14'h80, 32'hBEEF0055, 1'b0,4'b0000,32'h0,        3'd1};
    vt[10] = '{1'b0,1'b0,32'h0,       32'h0,     3'b000,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[11] = '{1'b1,1'b0,32'hC0000010,32'h1234,  3'b010,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[12] = '{1'b1,1'b0,32'h40,      32'h1234,  3'b010,1'b1,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[13] = '{1'b1,1'b0,32'h40,      32'h1234,  3'b011,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[14] = '{1'b0,1'b1,32'h40,      32'h0,     3'b010,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};
    vt[15] = '{1'b0,1'b0,32'h0,       32'h0,     3'b000,1'b0,1'b1, 1'b0,4'b0000,14'h0,  32'h0,        1'b0,4'b0000,32'h0,        3'd0};

    do_reset();

    // Same-cycle store to the draining head's word, then newest-wins forward.
    drive(1'b1, 1'b0, 32'h40, 32'hAAAAAAAA, 3'b010, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'h41, 32'h77, 3'b000, 1'b0, 1'b0);
    check("t6_stall", 32'(stall_sb), 32'h0);
    check("t6_wen", 32'(ram_wen), 32'hF);
    check("t6_wadr", 32'(ram_wadr), 32'h10);
    drive(1'b0, 1'b1, 32'h40, 32'h0, 3'b010, 1'b0, 1'b1);
    check("t6_count", 32'(sb_count), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1);
    check("t6_hit", 32'(fwd_hit_wb), 32'h1);
    check("t6_mask", 32'(fwd_mask_wb), 32'h2);
    check("t6_data", fwd_data_wb, 32'h00007700);
    check("t6_count_end", 32'(sb_count), 32'h1);

    // Reset with an entry still held discards it.
    do_reset();
    #2;
    check("rst_empty", 32'(sb_empty), 32'h1);
    check("rst_count", 32'(sb_count), 32'h0);
    check("rst_wen", 32'(ram_wen), 32'h0);
    check("rst_hit", 32'(fwd_hit_wb), 32'h0);
    check("rst_stall", 32'(stall_sb), 32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].st, vt[i].ld, vt[i].adr, vt[i].d, vt[i].code, vt[i].kill, vt[i].busy);
      check($sformatf("vec%0d_stall", i), 32'(stall_sb), 32'(vt[i].e_stall));
      check($sformatf("vec%0d_wen", i), 32'(ram_wen), 32'(vt[i].e_wen));
      if (vt[i].e_wen != 4'b0000) begin
        check($sformatf("vec%0d_wadr", i), 32'(ram_wadr), 32'(vt[i].e_wadr));
        check($sformatf("vec%0d_wdata", i), ram_wdata & bmask(vt[i].e_wen), vt[i].e_wdata);
      end
      check($sformatf("vec%0d_hit", i), 32'(fwd_hit_wb), 32'(vt[i].e_hit));
      check($sformatf("vec%0d_fmask", i), 32'(fwd_mask_wb), 32'(vt[i].e_fmask));
      check($sformatf("vec%0d_fdata", i), fwd_data_wb, vt[i].e_fdata);
      check($sformatf("vec%0d_count", i), 32'(sb_count), 32'(vt[i].e_count));
      check($sformatf("vec%0d_empty", i), 32'(sb_empty), 32'(vt[i].e_count == 3'd0));
    end

    // Full buffer: fifth store stalls, then slips in on the first drain.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h1000 + 32'(16 * i), 32'hA0 + 32'(i), 3'b010, 1'b0, 1'b1);
      check("t4_fill_stall", 32'(stall_sb), 32'h0);
    end
    drive(1'b1, 1'b0, 32'h1040, 32'hA4, 3'b010, 1'b0, 1'b1);
    check("t4_full_stall", 32'(stall_sb), 32'h1);
    check("t4_full_count", 32'(sb_count), 32'h4);
    drive(1'b1, 1'b0, 32'h1040, 32'hA4, 3'b010, 1'b0, 1'b0);
    check("t4_drain_accept", 32'(stall_sb), 32'h0);
    check("t4_first_wadr", 32'(ram_wadr), 32'h400);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
      if (c == 1) check("t4_count_after_swap", 32'(sb_count), 32'h4);
      if (ram_wen != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("t4_extra_drain", 32'(ram_wen), 32'h0);
        end else begin
          v = exp_q.pop_front();
          check("t4_wen", 32'(ram_wen), 32'hF);
          check("t4_order", ram_wdata, v);
        end
      end
    end
    check("t4_drained_all", exp_q.size(), 32'h0);
    check("t4_empty", 32'(sb_empty), 32'h1);

    // Random traffic over a few words to exercise merging and forwarding.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        st, ld, kill, busy, rstn;
      logic [31:0] adr;
      logic [2:0]  code;
      int          sel;
      sel  = $urandom_range(0, 9);
      st   = (sel < 4);
      ld   = (sel >= 4) && (sel < 7);
      adr  = 32'h100 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) adr[31:30] = 2'b11;
      code = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      kill = ($urandom_range(0, 9) == 0);
      busy = ($urandom_range(0, 1) == 1);
      rstn = ($urandom_range(0, 199) != 0);
      model_cycle(st, ld, adr, $urandom, code, kill, busy, rstn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
